// File: rtl/uart_recv.sv
// ----------------------------------------------------------------------------
// uart_recv
//
// Receives 8N1 asynchronous serial frames: idle-high line, one start bit,
// eight data bits LSB first and one stop bit. Each correctly framed byte is
// presented on data_o together with a one-cycle data_valid_o pulse. A frame
// whose stop bit samples low gives a one-cycle frame_err_o pulse instead and
// leaves data_o untouched.
//
// The receiver keeps its own bit-period counter and does not use any shared
// baud tick. Each bit is sampled once, at its middle: the start bit is
// re-checked half a bit after the falling edge, and every later sample point
// is a whole bit period after the one before it.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//   CNT_W         bit-period counter width (2**CNT_W > CLKS_PER_BIT)
//
// Ports
//   clk_i         system clock; all state changes on the rising edge
//   rst_i         synchronous, active-high reset; overrides everything else
//   rx_i          asynchronous serial input, idle high
//   data_o        last good byte; held until the next good frame
//   data_valid_o  one-cycle pulse: data_o has just been updated
//   frame_err_o   one-cycle pulse: the stop bit was sampled low
//   busy_o        high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_recv #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    // Half a bit period, rounded down. This is the delay from the detected
    // start edge to the middle of the start bit.
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    // Terminal counts. The counter runs 0 .. limit-1, so each phase lasts
    // exactly 'limit' cycles.
    localparam logic [CNT_W-1:0] HalfLast = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHi
    } state_e;

    // ------------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------------
    // Both flops reset high so that a reset never looks like a start edge.
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic half_done;
    logic bit_done;

    assign half_done = (cnt_q == HalfLast);
    assign bit_done  = (cnt_q == BitLast);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end

            StStart: begin
                if (half_done) begin
                    if (rx_s_q) begin
                        // Line is high again at mid start bit: treat as noise.
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StData: begin
                if (bit_done) begin
                    shreg_d[idx_q] = rx_s_q;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StStop: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = shreg_q;
                        data_valid_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        // Low stop bit: report it, keep the old byte, and do
                        // not rearm until the line has gone high again so a
                        // held-low break is not read as a run of 8'h00 frames.
                        frame_err_d = 1'b1;
                        state_d     = StWaitHi;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StWaitHi: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != StIdle);

endmodule
